// File: rtl/systolic_pkg.sv
// Shared types for the systolic operand feeder: pass FSM states, default operand width, index widths.
// Declarations only; no timing or flow control of its own.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int DEF_DW = 8;

  // Index width that stays at least one bit wide for single-entry ranges.
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/feeder_lane.sv
// One operand lane: K-deep buffer, read pointer and registered issue stage; issues 1 cycle after issue.
// No backpressure: an issue request on a non-exhausted lane always consumes one element.
module feeder_lane
  import systolic_pkg::*;
#(
  parameter int K  = 4,
  parameter int DW = DEF_DW,
  parameter int AW = addr_w(K)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          clr,
  input  logic          issue,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  output logic          exh,
  output logic          exh_nxt
);

  localparam int            PW = $clog2(K + 1);
  localparam logic [PW-1:0] KP = PW'(K);

  logic [DW-1:0] mem_q [K];
  logic [PW-1:0] ptr_q, ptr_d;
  logic [DW-1:0] data_q, data_d;
  logic          valid_q, valid_d;

  // Buffer contents survive reset so a pass can be replayed after an abort.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  always_comb begin
    ptr_d   = ptr_q;
    data_d  = '0;
    valid_d = 1'b0;
    if (clr) begin
      ptr_d = '0;
    end else if (issue && (ptr_q != KP)) begin
      ptr_d   = ptr_q + PW'(1);
      data_d  = mem_q[ptr_q[AW-1:0]];
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign exh       = (ptr_q == KP);
  assign exh_nxt   = (ptr_d == KP);

endmodule

// File: rtl/systolic_feeder.sv
// Operand feeder for an N x M systolic MAC array; operands appear 1 cycle after each sampled load.
// No backpressure: loads are consumed unconditionally, writes are dropped outside IDLE.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int N  = 2,
  parameter int M  = 2,
  parameter int K  = 4,
  parameter int DW = DEF_DW
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic                               load,
  input  logic [N-1:0]                       A_start_en,
  input  logic [M-1:0]                       B_start_en,
  input  logic                               wr_en,
  input  logic                               wr_sel,
  input  logic [addr_w((N > M) ? N : M)-1:0] wr_lane,
  input  logic [addr_w(K)-1:0]               wr_addr,
  input  logic [DW-1:0]                      wr_data,
  output logic [N*DW-1:0]                    a_data,
  output logic [N-1:0]                       a_valid,
  output logic [M*DW-1:0]                    b_data,
  output logic [M-1:0]                       b_valid,
  output logic                               finished,
  output logic                               busy,
  output logic                               done
);

  localparam int LW = addr_w((N > M) ? N : M);
  localparam int AW = addr_w(K);

  state_t         state_q, state_d;
  logic           finished_q, finished_d;
  logic           done_q, done_d;
  logic           clr, issue_ok, wr_ok;
  logic [N-1:0]   a_exh, a_exh_nxt;
  logic [M-1:0]   b_exh, b_exh_nxt;

  assign clr      = (state_q == IDLE) && start;
  assign issue_ok = load && ((state_q == RUN) || (state_q == DRAIN));
  assign wr_ok    = wr_en && (state_q == IDLE) && (int'(wr_addr) < K);

  for (genvar i = 0; i < N; i++) begin : g_a
    feeder_lane #(.K(K), .DW(DW), .AW(AW)) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (wr_ok && !wr_sel && (wr_lane == LW'(i))),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .clr       (clr),
      .issue     (issue_ok && A_start_en[i]),
      .out_data  (a_data[i*DW +: DW]),
      .out_valid (a_valid[i]),
      .exh       (a_exh[i]),
      .exh_nxt   (a_exh_nxt[i])
    );
  end

  for (genvar j = 0; j < M; j++) begin : g_b
    feeder_lane #(.K(K), .DW(DW), .AW(AW)) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (wr_ok && wr_sel && (wr_lane == LW'(j))),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .clr       (clr),
      .issue     (issue_ok && B_start_en[j]),
      .out_data  (b_data[j*DW +: DW]),
      .out_valid (b_valid[j]),
      .exh       (b_exh[j]),
      .exh_nxt   (b_exh_nxt[j])
    );
  end

  // RUN leaves on the edge that issues lane 0's last element, so finished lines up with that issue.
  always_comb begin
    state_d    = state_q;
    finished_d = finished_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = RUN;
          finished_d = 1'b0;
        end
      end
      RUN: begin
        if (a_exh_nxt[0] && b_exh_nxt[0]) begin
          state_d    = DRAIN;
          finished_d = 1'b1;
        end
      end
      DRAIN: begin
        if ((&a_exh) && (&b_exh)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    done_d = (state_d == DRAIN) && (&a_exh_nxt) && (&b_exh_nxt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      finished_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      finished_q <= finished_d;
      done_q     <= done_d;
    end
  end

  assign finished = finished_q;
  assign done     = done_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: doc/systolic_feeder.md
# systolic_feeder

Operand feeder for the N×M systolic MAC array: the responder to the load/start-enable sequencer. It buffers one K-deep operand stream per A row lane and per B column lane. On each sampled `load`, every lane whose start enable is set issues its next element, which produces the diagonal operand skew. It raises `finished` once lane 0 is exhausted, so the sequencer shifts zeros into its enable staircase and drains the remaining lanes.

## Interface
- N, 2, number of A row lanes
- M, 2, number of B column lanes
- K, 4, elements per lane (inner dimension), ≥1
- DW, 8, operand width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse to arm a pass; sampled only in IDLE
- load  in  1  advance strobe from sequencer, sampled at posedge
- A_start_en  in  N  per-row issue enable
- B_start_en  in  M  per-column issue enable
- wr_en  in  1  operand buffer write strobe
- wr_sel  in  1  0 = A buffer, 1 = B buffer
- wr_lane  in  clog2(max(N,M))  lane index
- wr_addr  in  clog2(K)  element index
- wr_data  in  DW  operand
- a_data  out  N*DW  lane i occupies bits [i*DW +: DW]
- a_valid  out  N  per-lane valid
- b_data  out  M*DW  per-lane operand
- b_valid  out  M  per-lane valid
- finished  out  1  lane 0 of A and B exhausted
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse when all lanes are exhausted

## Operation
- Reset values: state IDLE; all pointers 0; a_data, b_data, a_valid, b_valid, finished, busy and done all 0. Buffer contents are not reset.
- States are IDLE, RUN and DRAIN.
- IDLE → RUN on `start`. This clears every lane pointer and clears `finished`.
- RUN → DRAIN when A lane 0 and B lane 0 have both issued K elements.
- DRAIN → IDLE when every A and B lane pointer equals K. `done` pulses for exactly that cycle.
- Issue rule, at a posedge in RUN or DRAIN with load=1:
  - A lane i with A_start_en[i]=1 and ptr_i<K: a_data lane = buf[i][ptr_i], a_valid[i]=1, ptr_i increments.
  - Any other A lane: a_valid[i]=0 and a_data lane = 0.
  - B lanes follow the same rule.
- At a posedge with load=0, or in IDLE: all valids and all data are 0, and pointers hold.
- `finished` is set on entry to DRAIN. It stays high through DRAIN and IDLE, because the sequencer's momentum logic needs it held. It clears only on the next `start`.
- Writes:
  - Accepted only in IDLE.
  - Ignored while busy.
  - Ignored when wr_lane ≥ N (for A) or ≥ M (for B), or when wr_addr ≥ K.
- An enable set on an exhausted lane produces valid=0 and data=0. The pointer never exceeds K.
- `start` outside IDLE is ignored. `load` in IDLE is ignored.
- Reset mid-pass: returns to IDLE immediately and asynchronously, with every output at its reset value.

## Timing
- Operand latency is 1 cycle: data and valid are registered at the posedge that samples `load` and are visible until the next posedge.
- The enables are updated by the sequencer on the falling edge, so they are stable at each posedge.
- `finished` is registered. It is high the cycle after lane 0's K-th issue.
- `done`:
  - Registered, asserted the cycle after the final lane's K-th issue.
  - For a full staircase this is N-1 or M-1 loads after `finished`, whichever is larger.
- `busy` is high from the cycle after `start` through the `done` cycle inclusive.
- A write takes effect at its posedge and is readable by a pass started on the next cycle.

## Structure
- `systolic_pkg` holds the state enum (IDLE, RUN, DRAIN) and the default DW.
- Sub-module `feeder_lane` holds one lane's K×DW buffer, its pointer, the issue register and the exhausted flag. The feeder instantiates it N times for A and M times for B.
- The top level holds only the FSM, write decode and the finished/done logic.

## Test plan
All scenarios use N=M=2, K=3, DW=8.

- **Staircase pass.**
  - Stimulus: write A0={1,2,3}, A1={4,5,6}, B0={7,8,9}, B1={10,11,12}, then pulse start. Issue loads with enables 01, 11, 11, 10.
  - Response: A lanes emit (1,–), (2,4), (3,5), (–,6); B lanes mirror with 7–12.
  - Response: `finished` is high the cycle after the third load; `done` pulses the cycle after the fourth load.
- **No-load gaps.** Stimulus: alternate load=1 and load=0. Response: valid is 0 on every load=0 cycle, and the issued sequence matches the staircase pass exactly.
- **Over-enable.** Stimulus: hold both enables at 11 for 5 loads. Response: each lane issues exactly 3 elements, then valid=0 and data=0. `done` pulses once.
- **Ignored inputs.** Stimulus: a write to A0 during RUN, a `start` during RUN, and a `load` in IDLE. Response: the buffer is unchanged, no restart occurs, and no valid is asserted.
- **Reset mid-pass.** Stimulus: drop rst_n after the second load. Response: all outputs are 0 and `busy` is 0. A new `start` replays from element 1 using the retained buffer.
- **K=1 edge.** Stimulus: with K=1, one load with enables 11. Response: `finished` and `done` both assert the next cycle.
